// File: rtl/led_mode_controller_pkg.sv
// Shared definitions for the LED mode controller.
//   CLOCK_FREQUENCY_HZ : default system clock frequency in Hz
//   state_t            : operating mode (off, blinking, steady on)
//   freq_sel_t         : blink frequency index (1, 2, 5 or 10 Hz)
//   blink_period()     : blink timer period in clock cycles for a frequency index
//   next_mode()        : mode sequence advanced by each mode press
package definitions;

  localparam int unsigned CLOCK_FREQUENCY_HZ = 50_000_000;

  typedef enum logic [1:0] {
    STATE_OFF   = 2'd0,
    STATE_BLINK = 2'd1,
    STATE_ON    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FREQ_1HZ  = 2'd0,
    FREQ_2HZ  = 2'd1,
    FREQ_5HZ  = 2'd2,
    FREQ_10HZ = 2'd3
  } freq_sel_t;

  // Cycles between led toggles; clk_hz is a parameter, so this folds to a constant mux.
  function automatic int unsigned blink_period(input int unsigned clk_hz, input freq_sel_t f);
    int unsigned p;
    case (f)
      FREQ_1HZ: p = clk_hz;
      FREQ_2HZ: p = clk_hz / 2;
      FREQ_5HZ: p = clk_hz / 5;
      default:  p = clk_hz / 10;
    endcase
    return p;
  endfunction

  function automatic state_t next_mode(input state_t s);
    state_t n;
    case (s)
      STATE_OFF:   n = STATE_BLINK;
      STATE_BLINK: n = STATE_ON;
      default:     n = STATE_OFF;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Button conditioning: 2-flop synchroniser, rising-edge detector and per-button lockout.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   button  : raw asynchronous active-high button
//   press   : one-cycle pulse for each accepted press
// A press is visible on press one cycle before the consumer's registered update, so the
// consumer's outputs change on the 3rd rising edge after the button goes high.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  output logic press
);

  localparam int unsigned LockWidth = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  logic [1:0]           fill_q, fill_d;
  logic                 armed_q, armed_d;
  logic [LockWidth-1:0] lock_q, lock_d;
  logic                 rise;

  always_comb begin
    sync1_d = button;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    // fill_q[1] marks that sync2_q holds a real sample rather than its reset value.
    fill_d  = {fill_q[0], 1'b1};
    // Only arm once the button has been seen low, so a button held through reset
    // release does not look like a fresh press.
    armed_d = armed_q | (fill_q[1] & ~sync2_q);

    rise  = sync2_q & ~prev_q & armed_q;
    press = rise && (lock_q == '0);

    lock_d = lock_q;
    if (press) begin
      lock_d = LockWidth'(DEBOUNCE_CYCLES);
    end else if (lock_q != '0) begin
      lock_d = lock_q - LockWidth'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      lock_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      lock_q  <= lock_d;
    end
  end

endmodule

// File: rtl/led_mode_controller.sv
// LED mode controller: mode button cycles OFF -> BLINK -> ON -> OFF, frequency button
// steps the blink rate 1/2/5/10 Hz.
//   clock       : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   button_mode : raw mode button (active high)
//   button_freq : raw frequency button (active high)
//   led         : LED drive
//   state       : current mode
//   freq_sel    : blink frequency index
//   blink_tick  : one-cycle pulse on the last cycle of each blink period
module led_mode_controller #(
  parameter int unsigned CLOCK_FREQUENCY_HZ = definitions::CLOCK_FREQUENCY_HZ,
  parameter int unsigned DEBOUNCE_CYCLES    = CLOCK_FREQUENCY_HZ / 100
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                button_mode,
  input  logic                button_freq,
  output logic                led,
  output definitions::state_t state,
  output logic [1:0]          freq_sel,
  output logic                blink_tick
);

  import definitions::*;

  localparam int unsigned CntWidth = $clog2(CLOCK_FREQUENCY_HZ);

  if (CLOCK_FREQUENCY_HZ < 10 || (CLOCK_FREQUENCY_HZ % 10) != 0) begin : g_bad_clock
    $error("CLOCK_FREQUENCY_HZ must be at least 10 and a multiple of 10");
  end

  logic                mode_press, freq_press;
  state_t              state_q, state_d;
  freq_sel_t           freq_q, freq_d;
  logic                led_q, led_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] period_m1;
  logic [1:0]          freq_inc;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_debouncer (
    .clock  (clock),
    .reset_n(reset_n),
    .button (button_mode),
    .press  (mode_press)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_freq_debouncer (
    .clock  (clock),
    .reset_n(reset_n),
    .button (button_freq),
    .press  (freq_press)
  );

  assign period_m1  = CntWidth'(blink_period(CLOCK_FREQUENCY_HZ, freq_q) - 32'd1);
  assign blink_tick = (state_q == STATE_BLINK) && (cnt_q == period_m1);

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    led_d    = led_q;
    cnt_d    = '0;
    freq_inc = freq_q + 2'd1;

    if (state_q == STATE_BLINK) begin
      if (blink_tick) begin
        led_d = ~led_q;
      end else begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end

    // A frequency change restarts the period and holds the led, even on a tick cycle.
    if (freq_press) begin
      freq_d = freq_sel_t'(freq_inc);
      cnt_d  = '0;
      led_d  = led_q;
    end

    // Every mode entry starts with the led lit except OFF.
    if (mode_press) begin
      state_d = next_mode(state_q);
      cnt_d   = '0;
      led_d   = (state_d != STATE_OFF);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STATE_OFF;
      freq_q  <= FREQ_1HZ;
      led_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
    end
  end

  assign led      = led_q;
  assign state    = state_q;
  assign freq_sel = freq_q;

endmodule

// File: tb/tb_led_mode_controller.sv
module tb_led_mode_controller;
  import definitions::*;

  localparam int CLK_HZ = 100;
  localparam int DEB    = 4;

  logic       clock       = 1'b0;
  logic       reset_n     = 1'b0;
  logic       button_mode = 1'b0;
  logic       button_freq = 1'b0;
  logic       led;
  state_t     state;
  logic [1:0] freq_sel;
  logic       blink_tick;

  int errors = 0;
  int checks = 0;

  led_mode_controller #(
    .CLOCK_FREQUENCY_HZ(CLK_HZ),
    .DEBOUNCE_CYCLES   (DEB)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .button_mode(button_mode),
    .button_freq(button_freq),
    .led        (led),
    .state      (state),
    .freq_sel   (freq_sel),
    .blink_tick (blink_tick)
  );

  always #5 clock = ~clock;

  // Reference model: presses derived from the sampled input history, outputs from the
  // mode/frequency rules and the number of cycles spent in the current blink phase.
  state_t     m_st;
  logic [1:0] m_freq;
  logic       m_led;
  int         m_ph;
  int         m_edges;
  int         m_last_m;
  int         m_last_f;
  logic [2:0] hm;
  logic [2:0] hf;

  function automatic int tb_period(input logic [1:0] f);
    case (f)
      2'd0:    return CLK_HZ;
      2'd1:    return CLK_HZ / 2;
      2'd2:    return CLK_HZ / 5;
      default: return CLK_HZ / 10;
    endcase
  endfunction

  function automatic state_t tb_next(input state_t s);
    if (s == STATE_OFF) return STATE_BLINK;
    if (s == STATE_BLINK) return STATE_ON;
    return STATE_OFF;
  endfunction

  function automatic logic m_tick();
    return (m_st == STATE_BLINK) && (m_ph == tb_period(m_freq) - 1);
  endfunction

  always @(posedge clock or negedge reset_n) begin : model
    int         n;
    logic       pm;
    logic       pf;
    logic       tk;
    state_t     nst;
    logic [1:0] nf;
    logic       nled;
    int         nph;
    if (!reset_n) begin
      m_st     <= STATE_OFF;
      m_freq   <= 2'd0;
      m_led    <= 1'b0;
      m_ph     <= 0;
      m_edges  <= 0;
      m_last_m <= -1000;
      m_last_f <= -1000;
      hm       <= 3'b000;
      hf       <= 3'b000;
    end else begin
      n    = m_edges + 1;
      // Press lands two edges after the first high sample that follows a low sample.
      pm   = (n >= 4) && hm[1] && !hm[2] && (n - m_last_m > DEB);
      pf   = (n >= 4) && hf[1] && !hf[2] && (n - m_last_f > DEB);
      tk   = m_tick();
      nst  = m_st;
      nf   = m_freq;
      nled = m_led;
      nph  = 0;
      if (m_st == STATE_BLINK) begin
        if (tk) nled = !m_led;
        else    nph  = m_ph + 1;
      end
      if (pf) begin
        nf   = (m_freq == 2'd3) ? 2'd0 : m_freq + 2'd1;
        nph  = 0;
        nled = m_led;
      end
      if (pm) begin
        nst  = tb_next(m_st);
        nph  = 0;
        nled = (nst != STATE_OFF);
      end
      m_st   <= nst;
      m_freq <= nf;
      m_led  <= nled;
      m_ph   <= nph;
      if (pm) m_last_m <= n;
      if (pf) m_last_f <= n;
      hm      <= {hm[1:0], button_mode};
      hf      <= {hf[1:0], button_freq};
      m_edges <= n;
    end
  end

  task automatic press_mode();
    button_mode = 1'b1;
    @(negedge clock);
    button_mode = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (state !== STATE_OFF) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", state, STATE_OFF);
    end
    checks++;
    if (led !== 1'b0) begin
      errors++; $display("FAIL reset_led: got %0b expected 0", led);
    end
    checks++;
    if (freq_sel !== 2'd0) begin
      errors++; $display("FAIL reset_freq: got %0d expected 0", freq_sel);
    end
    checks++;
    if (blink_tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick: got %0b expected 0", blink_tick);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_blink();
    logic prev_led;
    logic prev_tick;
    int   last;
    int   toggles;
    button_mode = 1'b1;
    @(negedge clock);
    button_mode = 1'b0;
    @(negedge clock);
    checks++;
    if (state !== STATE_OFF) begin
      errors++; $display("FAIL blink_early: got %0d expected %0d", state, STATE_OFF);
    end
    @(negedge clock);
    checks++;
    if (state !== STATE_BLINK || led !== 1'b1) begin
      errors++;
      $display("FAIL blink_entry: got state=%0d led=%0b expected state=%0d led=1",
               state, led, STATE_BLINK);
    end
    prev_led  = led;
    prev_tick = blink_tick;
    last      = 0;
    toggles   = 0;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clock);
      if (led !== prev_led) begin
        toggles++;
        checks++;
        if (i - last != 100) begin
          errors++; $display("FAIL blink_period: got %0d expected 100", i - last);
        end
        checks++;
        if (prev_tick !== 1'b1) begin
          errors++; $display("FAIL blink_tick_before_toggle: got %0b expected 1", prev_tick);
        end
        last = i;
      end
      prev_led  = led;
      prev_tick = blink_tick;
    end
    checks++;
    if (toggles != 2) begin
      errors++; $display("FAIL blink_toggle_count: got %0d expected 2", toggles);
    end
  endtask

  task automatic test_freq();
    logic prev_led;
    int   t1;
    int   t2;
    for (int k = 0; k < 4; k++) begin
      button_freq = 1'b1;
      @(negedge clock);
      button_freq = 1'b0;
      repeat (9) @(negedge clock);
      if (k == 2 || k == 3) begin
        checks++;
        if (freq_sel !== ((k == 2) ? 2'd3 : 2'd0)) begin
          errors++;
          $display("FAIL freq_sel_after_%0d: got %0d expected %0d", k + 1, freq_sel,
                   (k == 2) ? 3 : 0);
        end
        t1       = -1;
        t2       = -1;
        prev_led = led;
        for (int i = 1; i <= ((k == 2) ? 40 : 250); i++) begin
          @(negedge clock);
          if (led !== prev_led) begin
            if (t1 < 0) t1 = i;
            else if (t2 < 0) t2 = i;
          end
          prev_led = led;
        end
        checks++;
        if (t2 < 0 || (t2 - t1) != ((k == 2) ? 10 : 100)) begin
          errors++;
          $display("FAIL freq_period_%0d: got %0d expected %0d", k + 1,
                   (t2 < 0) ? -1 : t2 - t1, (k == 2) ? 10 : 100);
        end
      end
    end
  endtask

  task automatic test_bounce();
    state_t s0;
    s0 = state;
    button_mode = 1'b1; @(negedge clock);
    button_mode = 1'b0; @(negedge clock);
    button_mode = 1'b1; @(negedge clock);
    button_mode = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (state !== tb_next(s0)) begin
      errors++; $display("FAIL bounce_single: got %0d expected %0d", state, tb_next(s0));
    end
    button_mode = 1'b1;
    repeat (2) @(negedge clock);
    button_mode = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (state !== tb_next(tb_next(s0))) begin
      errors++;
      $display("FAIL bounce_clean: got %0d expected %0d", state, tb_next(tb_next(s0)));
    end
  endtask

  task automatic test_simul();
    logic prev_led;
    int   first;
    button_mode = 1'b1;
    button_freq = 1'b1;
    @(negedge clock);
    button_mode = 1'b0;
    button_freq = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (state !== STATE_BLINK || freq_sel !== 2'd1 || led !== 1'b1) begin
      errors++;
      $display("FAIL simul_entry: got state=%0d freq=%0d led=%0b expected state=%0d freq=1 led=1",
               state, freq_sel, led, STATE_BLINK);
    end
    prev_led = led;
    first    = -1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clock);
      if (led !== prev_led && first < 0) first = i;
      prev_led = led;
    end
    checks++;
    if (first != 50) begin
      errors++; $display("FAIL simul_first_toggle: got %0d expected 50", first);
    end
  endtask

  task automatic test_reset_mid();
    logic prev_led;
    int   seen;
    prev_led = led;
    seen     = 0;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      @(negedge clock);
      if (led !== prev_led) seen = 1;
      prev_led = led;
    end
    checks++;
    if (seen == 0) begin
      errors++; $display("FAIL reset_mid_sync: got no toggle expected toggle within 60");
    end
    repeat (37) @(negedge clock);
    checks++;
    if (state !== STATE_BLINK) begin
      errors++; $display("FAIL reset_mid_pre: got %0d expected %0d", state, STATE_BLINK);
    end
    #2;
    reset_n     = 1'b0;
    button_mode = 1'b1;
    #1;
    checks++;
    if (state !== STATE_OFF || led !== 1'b0 || freq_sel !== 2'd0 || blink_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got state=%0d led=%0b freq=%0d tick=%0b expected 0 0 0 0",
               state, led, freq_sel, blink_tick);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    checks++;
    if (state !== STATE_OFF || led !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_button: got state=%0d led=%0b expected state=%0d led=0",
               state, led, STATE_OFF);
    end
    button_mode = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic test_cycle();
    int bad;
    press_mode();
    checks++;
    if (state !== STATE_BLINK || led !== 1'b1) begin
      errors++; $display("FAIL cycle_blink: got state=%0d led=%0b expected 1 1", state, led);
    end
    repeat (6) @(negedge clock);
    press_mode();
    checks++;
    if (state !== STATE_ON || led !== 1'b1) begin
      errors++; $display("FAIL cycle_on: got state=%0d led=%0b expected 2 1", state, led);
    end
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clock);
      if (blink_tick !== 1'b0 || led !== 1'b1 || state !== STATE_ON) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL cycle_on_hold: got %0d bad cycles expected 0", bad);
    end
    press_mode();
    checks++;
    if (state !== STATE_OFF || led !== 1'b0) begin
      errors++; $display("FAIL cycle_off: got state=%0d led=%0b expected 0 0", state, led);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      checks++;
      if (state !== m_st || led !== m_led || freq_sel !== m_freq || blink_tick !== m_tick()) begin
        errors++;
        $display("FAIL random_cycle_%0d: got st=%0d led=%0b f=%0d t=%0b expected %0d %0b %0d %0b",
                 i, state, led, freq_sel, blink_tick, m_st, m_led, m_freq, m_tick());
      end
      if ($urandom_range(0, 9) == 0) button_mode = ~button_mode;
      if ($urandom_range(0, 19) == 0) button_freq = ~button_freq;
    end
    button_mode = 1'b0;
    button_freq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_blink();
    test_freq();
    test_bounce();
    test_simul();
    test_reset_mid();
    test_cycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
